// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ requesters.
// Optional per-phase watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [7*NUM_REQ-1:0]  req_addr,
  input  logic [8*NUM_REQ-1:0]  req_reg,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [16*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    err,
  output logic [15:0]           rdata,
  output logic                  i2c_en,
  output logic [1:0]            i2c_mode,
  output logic [6:0]            i2c_addr,
  output logic [7:0]            i2c_reg,
  output logic                  i2c_rw,
  output logic [15:0]           i2c_din,
  input  logic [15:0]           i2c_dout,
  input  logic                  i2c_busy
);

  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W   = 3;
  localparam int unsigned TO_W     = 16;
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(3);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_ACTIVE  = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt, err_nxt;
  logic [15:0]        rdata_nxt, din_nxt;
  logic [6:0]         addr_nxt;
  logic [7:0]         reg_nxt;
  logic               en_nxt, rw_nxt, abort, to_hit;
  logic               busy_q, busy_s;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  int unsigned        cand;

  logic [6:0]  addr_arr  [NUM_REQ];
  logic [7:0]  reg_arr   [NUM_REQ];
  logic [15:0] wdata_arr [NUM_REQ];

  // Unreset synchroniser: busy seen during reset is still valid at release
  always_ff @(posedge clk) begin
    busy_q <= i2c_busy;
    busy_s <= busy_q;
  end

  assign i2c_mode = mode;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[7*g +: 7];
    assign reg_arr[g]   = req_reg[8*g +: 8];
    assign wdata_arr[g] = req_wdata[16*g +: 16];
  end

  // First pending request strictly after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;

  assign to_hit = (to_cnt == TO_LAST);

  // Fresh budget on each state change; frozen outside LAUNCH/ACTIVE
  always_comb begin
    to_cnt_nxt = to_cnt + TO_W'(1);
    if (state_nxt != state)
      to_cnt_nxt = '0;
    else if (state != S_LAUNCH && state != S_ACTIVE)
      to_cnt_nxt = to_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt <= '0;
    else        to_cnt <= to_cnt_nxt;
  end
`else
  logic unused_timeout;
  assign to_hit         = 1'b0;
  assign unused_timeout = ^TO_LAST;
`endif

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    hold_cnt_nxt = hold_cnt;
    grant_nxt    = grant;
    done_nxt     = '0;
    err_nxt      = '0;
    rdata_nxt    = rdata;
    en_nxt       = i2c_en;
    addr_nxt     = i2c_addr;
    reg_nxt      = i2c_reg;
    rw_nxt       = i2c_rw;
    din_nxt      = i2c_din;
    abort        = 1'b0;
    case (state)
      S_IDLE: begin
        if (busy_s) begin
          // controller still finishing a sequence begun before reset
          state_nxt    = S_HOLDOFF;
          hold_cnt_nxt = '0;
        end else if (win_found) begin
          addr_nxt   = addr_arr[win_idx];
          reg_nxt    = reg_arr[win_idx];
          rw_nxt     = req_rw[win_idx];
          din_nxt    = wdata_arr[win_idx];
          grant_nxt  = NUM_REQ'(1) << win_idx;
          rr_ptr_nxt = win_idx;
          en_nxt     = 1'b1;
          state_nxt  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (busy_s)      state_nxt = S_ACTIVE;
        else if (to_hit) abort     = 1'b1;
      end
      S_ACTIVE: begin
        if (!busy_s) begin
          en_nxt    = 1'b0;
          state_nxt = S_DONE;
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
      S_DONE: begin
        rdata_nxt    = i2c_dout;
        done_nxt     = grant;
        grant_nxt    = '0;
        hold_cnt_nxt = '0;
        state_nxt    = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (busy_s)                     hold_cnt_nxt = '0;
        else if (hold_cnt == HOLD_LAST) state_nxt    = S_IDLE;
        else                            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      en_nxt       = 1'b0;
      err_nxt      = grant;
      grant_nxt    = '0;
      hold_cnt_nxt = '0;
      state_nxt    = S_HOLDOFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= PTR_LAST;
      hold_cnt <= '0;
      grant    <= '0;
      done     <= '0;
      err      <= '0;
      rdata    <= '0;
      i2c_en   <= 1'b0;
      i2c_addr <= '0;
      i2c_reg  <= '0;
      i2c_rw   <= 1'b0;
      i2c_din  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      grant    <= grant_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      rdata    <= rdata_nxt;
      i2c_en   <= en_nxt;
      i2c_addr <= addr_nxt;
      i2c_reg  <= reg_nxt;
      i2c_rw   <= rw_nxt;
      i2c_din  <= din_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed steps plus randomized traffic
// scored against a round-robin reference model; timeout case under I2C_ARB_TIMEOUT_EN.
module tb_i2c_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TO = 50;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      mode;
  logic [N-1:0]    req, req_rw, grant, done, err;
  logic [7*N-1:0]  req_addr;
  logic [8*N-1:0]  req_reg;
  logic [16*N-1:0] req_wdata;
  logic [15:0]     rdata, i2c_din, i2c_dout;
  logic            i2c_en, i2c_rw, i2c_busy;
  logic [1:0]      i2c_mode;
  logic [6:0]      i2c_addr;
  logic [7:0]      i2c_reg;

  i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .req_addr(req_addr),
    .req_reg(req_reg), .req_rw(req_rw), .req_wdata(req_wdata), .grant(grant),
    .done(done), .err(err), .rdata(rdata), .i2c_en(i2c_en), .i2c_mode(i2c_mode),
    .i2c_addr(i2c_addr), .i2c_reg(i2c_reg), .i2c_rw(i2c_rw), .i2c_din(i2c_din),
    .i2c_dout(i2c_dout), .i2c_busy(i2c_busy)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          model_ptr;
  logic [6:0]  m_addr [N];
  logic [7:0]  m_reg  [N];
  logic        m_rw   [N];
  logic [15:0] m_wd   [N];
  logic [15:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic [6:0] a, input logic [7:0] r,
                            input logic w, input logic [15:0] d);
    m_addr[i] = a;
    m_reg[i]  = r;
    m_rw[i]   = w;
    m_wd[i]   = d;
    req_addr[7*i +: 7]   = a;
    req_reg[8*i +: 8]    = r;
    req_rw[IW'(i)]       = w;
    req_wdata[16*i +: 16] = d;
  endtask

  task automatic rand_fields(input int i);
    set_fields(i, 7'($urandom), 8'($urandom), 1'($urandom), 16'($urandom));
  endtask

  // Round-robin rule: first pending requester after the last winner, wrapping
  function automatic int exp_winner(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= int'(N); k++) begin
      if (r[IW'((ptr + k) % int'(N))]) return (ptr + k) % int'(N);
    end
    return 0;
  endfunction

  task automatic wait_grant(input int budget, output int cycles);
    cycles = 0;
    while (grant == '0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    chk("grant_wait", 32'(grant != '0), 32'd1);
  endtask

  // Act as the controller for the granted transaction and score the result
  task automatic serve(input int w, input logic [15:0] dval);
    int pre, len, k;
    pre = int'($urandom_range(0, 3));
    len = int'($urandom_range(1, 6));
    chk("grant_onehot", 32'(grant), 32'(1) << w);
    chk("i2c_addr", 32'(i2c_addr), 32'(m_addr[w]));
    chk("i2c_reg", 32'(i2c_reg), 32'(m_reg[w]));
    chk("i2c_rw", 32'(i2c_rw), 32'(m_rw[w]));
    chk("i2c_din", 32'(i2c_din), 32'(m_wd[w]));
    chk("i2c_en_launch", 32'(i2c_en), 32'd1);
    chk("i2c_mode", 32'(i2c_mode), 32'(mode));
    req_addr[7*w +: 7]    = ~m_addr[w];
    req_reg[8*w +: 8]     = ~m_reg[w];
    req_rw[IW'(w)]        = ~m_rw[w];
    req_wdata[16*w +: 16] = ~m_wd[w];
    repeat (pre) @(negedge clk);
    i2c_busy = 1'b1;
    repeat (len) @(negedge clk);
    chk("en_held", 32'(i2c_en), 32'd1);
    chk("addr_stable", 32'(i2c_addr), 32'(m_addr[w]));
    chk("din_stable", 32'(i2c_din), 32'(m_wd[w]));
    i2c_dout = dval;
    i2c_busy = 1'b0;
    k = 0;
    while (done == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("done", 32'(done), 32'(1) << w);
    chk("rdata", 32'(rdata), 32'(dval));
    chk("en_dropped", 32'(i2c_en), 32'd0);
    chk("grant_clear", 32'(grant), 32'd0);
    chk("err_quiet", 32'(err), 32'd0);
    last_rdata = dval;
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
  endtask

  task automatic txn(input logic [15:0] dval, output int w);
    int gap;
    wait_grant(60, gap);
    chk("holdoff_gap", 32'(gap >= 4), 32'd1);
    w = exp_winner(req, model_ptr);
    model_ptr = w;
    serve(w, dval);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, gap, bad;
    logic [N-1:0] nw;
    rst_n = 1'b1; req = '0; mode = 2'b01; i2c_busy = 1'b0; i2c_dout = '0;
    req_addr = '0; req_reg = '0; req_rw = '0; req_wdata = '0;
    model_ptr = int'(N) - 1;
    last_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_en", 32'(i2c_en), 32'd0);
    chk("rst_addr", 32'(i2c_addr), 32'd0);
    chk("rst_reg", 32'(i2c_reg), 32'd0);
    chk("rst_rw", 32'(i2c_rw), 32'd0);
    chk("rst_din", 32'(i2c_din), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_grant", 32'(grant), 32'd0);

    // single write request, one-cycle arbitration
    set_fields(1, 7'h48, 8'h01, 1'b1, 16'hA55A);
    req = 4'b0010;
    @(negedge clk);
    chk("arb_latency", 32'(grant), 32'h2);
    w = exp_winner(req, model_ptr);
    model_ptr = w;
    serve(w, 16'h0F0F);
    req = '0;

    // read returns controller dout
    set_fields(0, 7'($urandom), 8'($urandom), 1'b0, 16'($urandom));
    req = 4'b0001;
    txn(16'h1234, w);
    req = '0;

    // fairness across the pointer wrap
    rand_fields(3);
    req = 4'b1000;
    txn(16'($urandom), w);
    rand_fields(0);
    rand_fields(3);
    req = 4'b1001;
    txn(16'($urandom), w);
    chk("wrap_first", 32'(w), 32'd0);
    req[0] = 1'b0;
    txn(16'($urandom), w);
    req = '0;

    // full contention, requests held
    for (int i = 0; i < int'(N); i++) rand_fields(i);
    req = '1;
    for (int t = 0; t < 6; t++) begin
      txn(16'($urandom), w);
      rand_fields(w);
    end
    req = '0;

    // reset while ACTIVE with the controller still busy
    rand_fields(2);
    req = 4'b0100;
    wait_grant(60, gap);
    w = exp_winner(req, model_ptr);
    model_ptr = w;
    chk("rst_txn_grant", 32'(grant), 32'(1) << w);
    i2c_busy = 1'b1;
    repeat (5) @(negedge clk);
    chk("active_en", 32'(i2c_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_en", 32'(i2c_en), 32'd0);
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_rdata", 32'(rdata), 32'd0);
    last_rdata = '0;
    model_ptr = int'(N) - 1;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (grant != '0 || done != '0) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    i2c_busy = 1'b0;
    wait_grant(60, gap);
    chk("post_rst_holdoff", 32'(gap >= 6), 32'd1);
    w = exp_winner(req, model_ptr);
    model_ptr = w;
    serve(w, 16'($urandom));
    req = '0;

    // randomized traffic
    for (int t = 0; t < 25; t++) begin
      nw = N'($urandom);
      if ((req | nw) == '0) nw = N'(1) << $urandom_range(0, N - 1);
      for (int i = 0; i < int'(N); i++)
        if (nw[IW'(i)] && !req[IW'(i)]) rand_fields(i);
      req = req | nw;
      if (t % 5 == 0) mode = 2'($urandom);
      txn(16'($urandom), w);
      req[IW'(w)] = 1'b0;
    end
    req = '0;

`ifdef I2C_ARB_TIMEOUT_EN
    // controller never answers: abort after TO cycles in LAUNCH
    rand_fields(1);
    rand_fields(2);
    req = 4'b0110;
    wait_grant(60, gap);
    w = exp_winner(req, model_ptr);
    model_ptr = w;
    chk("to_grant", 32'(grant), 32'(1) << w);
    gap = 0;
    while (err == '0 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    chk("to_cycles", 32'(gap), 32'(TO));
    chk("to_err", 32'(err), 32'(1) << w);
    chk("to_no_done", 32'(done), 32'd0);
    chk("to_grant_clear", 32'(grant), 32'd0);
    chk("to_en", 32'(i2c_en), 32'd0);
    chk("to_rdata_kept", 32'(rdata), 32'(last_rdata));
    req[IW'(w)] = 1'b0;
    txn(16'($urandom), w);
    req = '0;
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
